divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//   Shares one combinational divider (OperA/OperD -> Quotient/Remainder) between two requesters.
//   Round-robin arbitration; registers the winner's operands onto the divider and waits DIV_LATENCY
//   cycles for settling. Returns the result to that requester over a valid/ready response.
//   Divide-by-zero is trapped without using the divider.
//   Sits between the two client blocks and the divider instance.
// PARAMETERS
//   DEVIDENT_LENGTH  10  dividend and quotient width
//   DIVISOR_LENGTH   5   divisor and remainder width
//   DIV_LATENCY      1   cycles the divider output needs to settle after operands are registered (>=1)
// PORTS
//   CLK            in   1                clock, rising edge
//   RST            in   1                synchronous reset, active-high
//   REQ_Valid      in   2                per-requester request valid (bit n = requester n)
//   REQ_Ready      out  2                per-requester accept (combinational, one-hot or zero)
//   REQ0_OperA     in   DEVIDENT_LENGTH  requester 0 dividend
//   REQ0_OperD     in   DIVISOR_LENGTH   requester 0 divisor
//   REQ1_OperA     in   DEVIDENT_LENGTH  requester 1 dividend
//   REQ1_OperD     in   DIVISOR_LENGTH   requester 1 divisor
//   RSP_Valid      out  2                one-hot: result valid for requester n
//   RSP_Ready      in   2                per-requester response accept
//   RSP_Quotient   out  DEVIDENT_LENGTH  registered quotient
//   RSP_Remainder  out  DIVISOR_LENGTH   registered remainder
//   RSP_DivZero    out  1                result came from a zero divisor
//   Div_OperA      out  DEVIDENT_LENGTH  to divider OperA (registered)
//   Div_OperD      out  DIVISOR_LENGTH   to divider OperD (registered)
//   Div_Quotient   in   DEVIDENT_LENGTH  from divider Quotient
//   Div_Remainder  in   DIVISOR_LENGTH   from divider Remainder
//   Busy           out  1                state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=1, wait counter=0, every output register=0 (RSP_*, Div_*, Busy).
//   FSM states:
//   - IDLE: REQ_Ready = grant(REQ_Valid).
//     - Grant rule: only one request valid -> grant it. Both valid -> grant the requester != last_grant.
//     - Accept = REQ_Valid[n] & REQ_Ready[n]. On accept: last_grant<=n and owner<=n.
//     - Divisor != 0: Div_OperA/OperD<=operands; cnt<=0; go WAIT.
//     - Divisor == 0: RSP_Quotient<=all ones; RSP_Remainder<=0; RSP_DivZero<=1; go RESP.
//       Div_* are left unchanged.
//   - WAIT: REQ_Ready=0; cnt increments each cycle. When cnt==DIV_LATENCY-1:
//     - RSP_Quotient<=Div_Quotient; RSP_Remainder<=Div_Remainder; RSP_DivZero<=0; go RESP.
//   - RESP: RSP_Valid[owner]=1, all RSP_* held stable, REQ_Ready=0.
//     - RSP_Ready[owner]=1 -> go IDLE next cycle; RSP_Ready of the non-owner is ignored.
//   Latency (accept in cycle 0):
//   - Normal: RSP_Valid in cycle DIV_LATENCY+1.
//   - Divide-by-zero: RSP_Valid in cycle 1.
//   - Minimum spacing between accepts: DIV_LATENCY+2 cycles (one in flight; no accept in RESP).
//   Handshake rules:
//   - A requester holds Valid and operands until it sees Ready.
//   - Dropping Valid before Ready is legal; no operation is started.
//   Widths: operands captured unmodified. Results are exactly the divider's widths; no truncation logic.
//   Reset mid-operation (any state): operation discarded, no response; IDLE next cycle.
//   Requests held across reset are re-arbitrated with last_grant=1.
// TESTING
//   - REQ0 21/7, RSP_Ready=1 -> RSP_Valid=2'b01 in cycle 2; Q=3 R=0 DivZero=0.
//   - Both valid, REQ0 25/7, REQ1 28/7 after reset -> REQ0 served first (Q=3 R=4), then REQ1 (Q=4 R=0).
//     Next simultaneous pair is granted to REQ1.
//   - REQ1 14/0 -> RSP_Valid=2'b10 in cycle 1; Q=10'h3FF R=0 DivZero=1; Div_* unchanged.
//   - RSP_Ready low 5 cycles while REQ1 also valid -> results stable, REQ_Ready=0.
//     REQ1 is accepted in the cycle after RSP_Ready[0] rises.
//   - RST high during WAIT with REQ0 12/3 -> RSP_Valid never rises.
//     Next cycle IDLE, REQ_Ready=2'b01 if REQ0 still valid.
//   - DIV_LATENCY=3, REQ0 1023/1 -> RSP_Valid in cycle 4; Q=1023 R=0.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin share of one combinational divider between two requesters
// Ports:
//   CLK, RST                      clock (rising edge), synchronous active-high reset
//   REQ_Valid/REQ_Ready [1:0]     per-requester request handshake (bit n = requester n)
//   REQn_OperA/REQn_OperD         requester n dividend / divisor
//   RSP_Valid/RSP_Ready [1:0]     per-requester response handshake, RSP_Valid one-hot
//   RSP_Quotient/Remainder/DivZero registered result returned to the owner
//   Div_OperA/Div_OperD           registered operands driven to the divider
//   Div_Quotient/Div_Remainder    divider results
//   Busy                          high whenever an operation is in flight
module divider_arbiter #(
   parameter int DEVIDENT_LENGTH = 10,
   parameter int DIVISOR_LENGTH  = 5,
   parameter int DIV_LATENCY     = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [1:0]                 REQ_Valid,
   output logic [1:0]                 REQ_Ready,
   input  logic [DEVIDENT_LENGTH-1:0] REQ0_OperA,
   input  logic [DIVISOR_LENGTH-1:0]  REQ0_OperD,
   input  logic [DEVIDENT_LENGTH-1:0] REQ1_OperA,
   input  logic [DIVISOR_LENGTH-1:0]  REQ1_OperD,
   output logic [1:0]                 RSP_Valid,
   input  logic [1:0]                 RSP_Ready,
   output logic [DEVIDENT_LENGTH-1:0] RSP_Quotient,
   output logic [DIVISOR_LENGTH-1:0]  RSP_Remainder,
   output logic                       RSP_DivZero,
   output logic [DEVIDENT_LENGTH-1:0] Div_OperA,
   output logic [DIVISOR_LENGTH-1:0]  Div_OperD,
   input  logic [DEVIDENT_LENGTH-1:0] Div_Quotient,
   input  logic [DIVISOR_LENGTH-1:0]  Div_Remainder,
   output logic                       Busy
);
   localparam int CW = DIV_LATENCY > 1 ? $clog2(DIV_LATENCY) : 1;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   state_t                     state_q, state_d;
   logic                       last_grant_q, last_grant_d;
   logic                       owner_q, owner_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [DEVIDENT_LENGTH-1:0] rsp_quo_q, rsp_quo_d;
   logic [DIVISOR_LENGTH-1:0]  rsp_rem_q, rsp_rem_d;
   logic                       rsp_dz_q, rsp_dz_d;
   logic [DEVIDENT_LENGTH-1:0] div_a_q, div_a_d;
   logic [DIVISOR_LENGTH-1:0]  div_d_q, div_d_d;
   logic [1:0]                 grant, accept;
   logic [DEVIDENT_LENGTH-1:0] sel_a;
   logic [DIVISOR_LENGTH-1:0]  sel_d;
   // contention goes to whichever requester was not served last
   assign grant     = (&REQ_Valid) ? (last_grant_q ? 2'b01 : 2'b10) : REQ_Valid;
   assign REQ_Ready = (state_q == ST_IDLE) ? grant : 2'b00;
   assign accept    = REQ_Valid & REQ_Ready;
   assign sel_a     = accept[1] ? REQ1_OperA : REQ0_OperA;
   assign sel_d     = accept[1] ? REQ1_OperD : REQ0_OperD;
   assign RSP_Valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign RSP_Quotient  = rsp_quo_q;
   assign RSP_Remainder = rsp_rem_q;
   assign RSP_DivZero   = rsp_dz_q;
   assign Div_OperA     = div_a_q;
   assign Div_OperD     = div_d_q;
   assign Busy          = state_q != ST_IDLE;
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      rsp_quo_d    = rsp_quo_q;
      rsp_rem_d    = rsp_rem_q;
      rsp_dz_d     = rsp_dz_q;
      div_a_d      = div_a_q;
      div_d_d      = div_d_q;
      case (state_q)
         ST_IDLE: if (|accept) begin
            last_grant_d = accept[1];
            owner_d      = accept[1];
            // a zero divisor is answered directly and never reaches the divider
            if (sel_d == '0) begin
               rsp_quo_d = '1;
               rsp_rem_d = '0;
               rsp_dz_d  = 1'b1;
               state_d   = ST_RESP;
            end else begin
               div_a_d = sel_a;
               div_d_d = sel_d;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DIV_LATENCY - 1)) begin
               rsp_quo_d = Div_Quotient;
               rsp_rem_d = Div_Remainder;
               rsp_dz_d  = 1'b0;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: state_d = RSP_Ready[owner_q] ? ST_IDLE : ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         rsp_quo_q    <= '0;
         rsp_rem_q    <= '0;
         rsp_dz_q     <= 1'b0;
         div_a_q      <= '0;
         div_d_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         rsp_quo_q    <= rsp_quo_d;
         rsp_rem_q    <= rsp_rem_d;
         rsp_dz_q     <= rsp_dz_d;
         div_a_q      <= div_a_d;
         div_d_q      <= div_d_d;
      end
   end
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed self-checking bench for divider_arbiter (latency 1 and 3)
module tb_divider_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
   logic [9:0] a0 = '0, a1 = '0, rsp_q, div_a, div_q;
   logic [4:0] d0 = '0, d1 = '0, rsp_r, div_d, div_r;
   logic       rsp_dz, busy;
   logic [1:0] req_valid3 = '0, req_ready3, rsp_valid3, rsp_ready3 = '0;
   logic [9:0] a3 = '0, rsp_q3, div_a3, div_q3;
   logic [4:0] d3 = '0, rsp_r3, div_d3, div_r3;
   logic       rsp_dz3, busy3;
   int         checks = 0, passed = 0;
   always #5 clk = ~clk;
   assign div_q  = (div_d == 5'd0) ? '1 : div_a / 10'(div_d);
   assign div_r  = (div_d == 5'd0) ? '0 : 5'(div_a % 10'(div_d));
   assign div_q3 = (div_d3 == 5'd0) ? '1 : div_a3 / 10'(div_d3);
   assign div_r3 = (div_d3 == 5'd0) ? '0 : 5'(div_a3 % 10'(div_d3));
   divider_arbiter #(.DEVIDENT_LENGTH(10), .DIVISOR_LENGTH(5), .DIV_LATENCY(1)) dut (
      .CLK(clk), .RST(rst), .REQ_Valid(req_valid), .REQ_Ready(req_ready),
      .REQ0_OperA(a0), .REQ0_OperD(d0), .REQ1_OperA(a1), .REQ1_OperD(d1),
      .RSP_Valid(rsp_valid), .RSP_Ready(rsp_ready), .RSP_Quotient(rsp_q),
      .RSP_Remainder(rsp_r), .RSP_DivZero(rsp_dz), .Div_OperA(div_a), .Div_OperD(div_d),
      .Div_Quotient(div_q), .Div_Remainder(div_r), .Busy(busy));
   divider_arbiter #(.DEVIDENT_LENGTH(10), .DIVISOR_LENGTH(5), .DIV_LATENCY(3)) dut3 (
      .CLK(clk), .RST(rst), .REQ_Valid(req_valid3), .REQ_Ready(req_ready3),
      .REQ0_OperA(a3), .REQ0_OperD(d3), .REQ1_OperA(10'd0), .REQ1_OperD(5'd0),
      .RSP_Valid(rsp_valid3), .RSP_Ready(rsp_ready3), .RSP_Quotient(rsp_q3),
      .RSP_Remainder(rsp_r3), .RSP_DivZero(rsp_dz3), .Div_OperA(div_a3), .Div_OperD(div_d3),
      .Div_Quotient(div_q3), .Div_Remainder(div_r3), .Busy(busy3));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   initial begin
      step();
      step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_div_a", 32'(div_a), 0);
      chk("rst_rsp_q", 32'(rsp_q), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      rst = 1'b0;
      step();
      req_valid = 2'b01; a0 = 10'd21; d0 = 5'd7; rsp_ready = 2'b01;
      #1 chk("t1_req_ready", 32'(req_ready), 32'b01);
      step();
      req_valid = 2'b00;
      chk("t1_busy", 32'(busy), 1);
      chk("t1_c1_rsp_valid", 32'(rsp_valid), 0);
      chk("t1_div_a", 32'(div_a), 21);
      chk("t1_div_d", 32'(div_d), 7);
      step();
      chk("t1_c2_rsp_valid", 32'(rsp_valid), 32'b01);
      chk("t1_q", 32'(rsp_q), 3);
      chk("t1_r", 32'(rsp_r), 0);
      chk("t1_dz", 32'(rsp_dz), 0);
      step();
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_idle_rsp_valid", 32'(rsp_valid), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 2'b11; a0 = 10'd25; d0 = 5'd7; a1 = 10'd28; d1 = 5'd7; rsp_ready = 2'b11;
      #1 chk("t2_first_grant", 32'(req_ready), 32'b01);
      step();
      chk("t2_wait_ready", 32'(req_ready), 0);
      step();
      chk("t2_rsp0_valid", 32'(rsp_valid), 32'b01);
      chk("t2_rsp0_q", 32'(rsp_q), 3);
      chk("t2_rsp0_r", 32'(rsp_r), 4);
      step();
      chk("t2_second_grant", 32'(req_ready), 32'b10);
      step();
      req_valid = 2'b01;
      step();
      chk("t2_rsp1_valid", 32'(rsp_valid), 32'b10);
      chk("t2_rsp1_q", 32'(rsp_q), 4);
      chk("t2_rsp1_r", 32'(rsp_r), 0);
      rsp_ready = 2'b01;
      step();
      chk("t2_nonowner_ignored", 32'(rsp_valid), 32'b10);
      rsp_ready = 2'b10;
      step();
      chk("t2_idle_ready", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      step();
      chk("t2_drop_no_start", 32'(busy), 0);
      req_valid = 2'b10; a1 = 10'd14; d1 = 5'd0;
      #1 chk("t3_req_ready", 32'(req_ready), 32'b10);
      step();
      req_valid = 2'b00;
      chk("t3_rsp_valid", 32'(rsp_valid), 32'b10);
      chk("t3_q", 32'(rsp_q), 32'h3FF);
      chk("t3_r", 32'(rsp_r), 0);
      chk("t3_dz", 32'(rsp_dz), 1);
      chk("t3_div_a_kept", 32'(div_a), 28);
      chk("t3_div_d_kept", 32'(div_d), 7);
      step();
      chk("t3_idle", 32'(busy), 0);
      req_valid = 2'b01; a0 = 10'd100; d0 = 5'd9; rsp_ready = 2'b00;
      #1 chk("t4_req_ready", 32'(req_ready), 32'b01);
      step();
      req_valid = 2'b10; a1 = 10'd30; d1 = 5'd4;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 32'(rsp_valid), 32'b01);
         chk("t4_hold_q", 32'(rsp_q), 11);
         chk("t4_hold_r", 32'(rsp_r), 1);
         chk("t4_hold_ready", 32'(req_ready), 0);
         step();
      end
      rsp_ready = 2'b01;
      #1 chk("t4_resp_no_accept", 32'(req_ready), 0);
      step();
      chk("t4_req1_ready", 32'(req_ready), 32'b10);
      step();
      req_valid = 2'b00; rsp_ready = 2'b10;
      chk("t4_req1_busy", 32'(busy), 1);
      chk("t4_req1_div_a", 32'(div_a), 30);
      step();
      chk("t4_rsp1_valid", 32'(rsp_valid), 32'b10);
      chk("t4_rsp1_q", 32'(rsp_q), 7);
      chk("t4_rsp1_r", 32'(rsp_r), 2);
      step();
      req_valid = 2'b01; a0 = 10'd12; d0 = 5'd3; rsp_ready = 2'b01;
      step();
      chk("t5_in_wait", 32'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_rst_idle", 32'(busy), 0);
      chk("t5_rst_div_a", 32'(div_a), 0);
      chk("t5_rearb_ready", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      step();
      chk("t5_after_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_after_busy", 32'(busy), 0);
      req_valid3 = 2'b01; a3 = 10'd1023; d3 = 5'd1; rsp_ready3 = 2'b01;
      #1 chk("t6_req_ready", 32'(req_ready3), 32'b01);
      step();
      req_valid3 = 2'b00;
      for (int i = 1; i < 4; i++) begin
         chk("t6_not_yet", 32'(rsp_valid3), 0);
         step();
      end
      chk("t6_rsp_valid", 32'(rsp_valid3), 32'b01);
      chk("t6_q", 32'(rsp_q3), 1023);
      chk("t6_r", 32'(rsp_r3), 0);
      step();
      chk("t6_idle", 32'(busy3), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
